mtx_iq_framer: RTL and testbench
================================

MTX_IQ_FRAMER -- requirements
Module: mtx_iq_framer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit width of each sin/cos sample.
REQ-002 SHALL have parameter SPP_WIDTH, default 16, bit width of the frame-length counter.
REQ-003 SHALL have parameter [SPP_WIDTH-1:0] SPP, default 256, samples per output frame (legal range 2..2^SPP_WIDTH-1).
REQ-004 SHALL have parameter GAIN_FRAC, default 14, number of fractional bits of gain.
REQ-005 clk  in  1  clock; all logic on the rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 srst  in  1  synchronous soft reset, active-high; identical effect to reset.
REQ-008 enable  in  1  level; requests framed output.
REQ-009 sync_ready  in  1  upstream symbol-group sync flag.
REQ-010 gain  in  16  unsigned gain, UQ(16-GAIN_FRAC).GAIN_FRAC; 0x4000 = 1.0 at the default.
REQ-011 in_tvalid / in_tready / in_tlast  in / out / in  1 each  AXI-Stream slave; in_tlast is ignored.
REQ-012 in_sin, in_cos  in  WIDTH each  signed two's-complement Q and I samples.
REQ-013 out_tvalid / out_tready / out_tlast  out / in / out  1 each  AXI-Stream master.
REQ-014 out_tdata  out  2*WIDTH  {I, Q} = {scaled cos, scaled sin}.
REQ-015 frame_count  out  16  completed frames, wraps modulo 2^16.
REQ-016 sat_count  out  16  saturated beats; sticks at 0xFFFF.
REQ-017 state  out  2  debug: 0 = IDLE, 1 = ARMED, 2 = RUN.

Function
REQ-018 A transfer SHALL occur on a port only in a cycle where tvalid and tready are both 1.
REQ-019 In IDLE, in_tready SHALL be 1 and every input beat SHALL be discarded.
REQ-020 IDLE SHALL go to ARMED on the first cycle in which enable = 1.
REQ-021 In ARMED, in_tready SHALL be 1 and input beats SHALL be discarded.
REQ-022 ARMED SHALL go to RUN after the first discarded transfer with sync_ready = 1; the next accepted beat is frame sample 1.
REQ-023 ARMED SHALL return to IDLE if enable = 0.
REQ-024 In RUN, in_tready SHALL equal (~stage2_valid | out_tready).
REQ-025 The pipeline SHALL be 2 stages: stage 1 registers the product, stage 2 registers the rounded, saturated result.
REQ-026 Latency SHALL be 2 cycles from input transfer to out_tvalid when the output is not stalled.
REQ-027 While stalled (out_tvalid = 1, out_tready = 0), out_tdata and out_tlast SHALL hold and no beat SHALL be lost or duplicated.
REQ-028 Gain SHALL be latched on frame sample 1 and used for the whole frame.
REQ-029 Arithmetic per component: signed product of sample × {1'b0, gain}, full width.
REQ-030 Rounding: add 2^(GAIN_FRAC-1), then arithmetic shift right by GAIN_FRAC (round half up).
REQ-031 Saturation: results above 2^(WIDTH-1)-1 SHALL clamp to the positive maximum, and results below -2^(WIDTH-1) SHALL clamp to the negative minimum.
REQ-032 sat_count SHALL increment by 1 per output transfer in which I or Q, or both, clamped.
REQ-033 out_tlast SHALL be 1 on output sample SPP of each frame; frame_count SHALL increment on that transfer.
REQ-034 If enable = 0 in RUN, the block SHALL finish the current frame (accept up to sample SPP) and then stop accepting input.
REQ-035 After that frame's last output transfer, the state SHALL go to IDLE; no partial frame SHALL ever be emitted.
REQ-036 If sync_ready changes during RUN, it SHALL have no effect.
REQ-037 When the sample counter reaches SPP, it SHALL wrap to 1 on the next accepted beat, with no idle gap between frames.

Reset
REQ-038 On reset or srst, the state SHALL go to IDLE.
REQ-039 On reset or srst, both pipeline valid bits SHALL clear, and out_tvalid, out_tlast and out_tdata SHALL be 0.
REQ-040 On reset or srst, frame_count, sat_count and the sample counter SHALL be 0.
REQ-041 Reset or srst asserted mid-frame SHALL discard in-flight beats with no tlast emitted; with enable still 1, the block goes to ARMED on the first cycle after reset deasserts.
REQ-042 in_tready SHALL be 0 while reset or srst is asserted.

Verification
REQ-043 Bench SHALL cover: gain = 0x4000, out_tready = 1, sync_ready pulse, ramp input -> output equals input delayed 2 cycles; out_tlast every 256 beats; frame_count counts 1, 2, 3.
REQ-044 Bench SHALL cover: gain = 0x8000, in_cos = 0x7000 -> I = 0x7FFF; in_cos = 0x9000 -> I = 0x8000; sat_count increments once per beat.
REQ-045 Bench SHALL cover: gain = 0x2000, in_sin = 3 -> Q = 2 (1.5 rounded up); in_sin = -3 -> Q = -1.
REQ-046 Bench SHALL cover: random out_tready at 30% -> output sequence identical to the unstalled run; out_tdata stable during stalls.
REQ-047 Bench SHALL cover: enable dropped at frame sample 100 -> exactly 256 beats in that frame, then IDLE; in_tready = 1 thereafter and no output.
REQ-048 Bench SHALL cover: srst at frame sample 50 -> out_tvalid = 0 the next cycle, counters = 0; re-arm waits for sync_ready.

Source files
------------

// File: rtl/mtx_iq_framer.sv
// rtl/mtx_iq_framer.sv - gain-scaled I/Q stream framer with sync arming and 2-stage pipeline
module mtx_iq_framer #(
  parameter int                   WIDTH     = 16,
  parameter int                   SPP_WIDTH = 16,
  parameter logic [SPP_WIDTH-1:0] SPP       = SPP_WIDTH'(256),
  parameter int                   GAIN_FRAC = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 srst,
  input  logic                 enable,
  input  logic                 sync_ready,
  input  logic [15:0]          gain,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic                 in_tlast,
  input  logic [WIDTH-1:0]     in_sin,
  input  logic [WIDTH-1:0]     in_cos,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_tlast,
  output logic [2*WIDTH-1:0]   out_tdata,
  output logic [15:0]          frame_count,
  output logic [15:0]          sat_count,
  output logic [1:0]           state
);

  // Product width: WIDTH-bit signed sample times 17-bit non-negative gain.
  localparam int PW = WIDTH + 17;
  localparam logic signed [PW-1:0] HALF = PW'(64'd1 << (GAIN_FRAC - 1));
  localparam logic signed [PW-1:0] MAXP = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINP = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                 in_rst;
  logic                 stopping_q;
  logic [SPP_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [15:0]          gain_q, gain_use;
  logic                 s1_valid, s1_last;
  logic signed [PW-1:0] s1_prod_i, s1_prod_q;
  logic signed [PW-1:0] prod_i, prod_q;
  logic signed [PW-1:0] rnd_i, rnd_q;
  logic [WIDTH-1:0]     res_i, res_q;
  logic                 sat_i, sat_q, s2_sat;
  logic                 pipe_adv, stop_now, frame_open, first_sample, last_sample;
  logic                 take, out_fire;
  logic                 unused_tlast;

  assign unused_tlast = in_tlast;
  assign in_rst       = reset | srst;
  assign state        = state_q;

  assign pipe_adv     = ~out_tvalid | out_tready;
  assign out_fire     = out_tvalid & out_tready;
  // Enable low in RUN is remembered so a brief re-assert cannot extend the stop.
  assign stop_now     = stopping_q | ~enable;
  assign frame_open   = (cnt_q != '0) && (cnt_q != SPP);
  assign first_sample = (cnt_q == '0) || (cnt_q == SPP);
  assign last_sample  = !first_sample && (cnt_q == SPP - 1'b1);
  assign cnt_nxt      = first_sample ? SPP_WIDTH'(1) : cnt_q + 1'b1;
  assign take         = in_tvalid & in_tready & (state_q == RUN);
  // Sample 1 uses the live gain so the latch and the first product agree.
  assign gain_use     = first_sample ? gain : gain_q;

  // State register.
  always_ff @(posedge clk) begin
    if (in_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; RUN only exits once the pipeline has drained a whole frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = ARMED;
      ARMED: begin
        if (!enable)                       state_d = IDLE;
        else if (in_tvalid && sync_ready)  state_d = RUN;
      end
      RUN: begin
        if (stop_now && !frame_open && !s1_valid && (!out_tvalid || out_tready))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: discard freely outside RUN, backpressure and frame gating in RUN.
  always_comb begin
    in_tready = 1'b0;
    if (!in_rst) begin
      case (state_q)
        IDLE, ARMED: in_tready = 1'b1;
        RUN:         in_tready = pipe_adv & (~stop_now | frame_open);
        default:     in_tready = 1'b0;
      endcase
    end
  end

  // Stop request, sample counter and per-frame gain latch.
  always_ff @(posedge clk) begin
    if (in_rst || state_q != RUN) begin
      stopping_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      if (!enable) stopping_q <= 1'b1;
      if (take)    cnt_q      <= cnt_nxt;
    end
    if (in_rst)                   gain_q <= '0;
    else if (take && first_sample) gain_q <= gain;
  end

  // Full-width signed products for stage 1.
  always_comb begin
    prod_i = PW'($signed(in_cos)) * PW'($signed({1'b0, gain_use}));
    prod_q = PW'($signed(in_sin)) * PW'($signed({1'b0, gain_use}));
  end

  // Stage 1: register products; empties when stage 2 takes it without a refill.
  always_ff @(posedge clk) begin
    if (in_rst) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_prod_i <= '0;
      s1_prod_q <= '0;
    end else if (take) begin
      s1_valid  <= 1'b1;
      s1_last   <= last_sample;
      s1_prod_i <= prod_i;
      s1_prod_q <= prod_q;
    end else if (pipe_adv) begin
      s1_valid  <= 1'b0;
    end
  end

  // Round half up, then clamp each component to the signed WIDTH range.
  always_comb begin
    rnd_i = (s1_prod_i + HALF) >>> GAIN_FRAC;
    rnd_q = (s1_prod_q + HALF) >>> GAIN_FRAC;
    res_i = rnd_i[WIDTH-1:0];
    res_q = rnd_q[WIDTH-1:0];
    sat_i = 1'b0;
    sat_q = 1'b0;
    if (rnd_i > MAXP)      begin res_i = MAXP[WIDTH-1:0]; sat_i = 1'b1; end
    else if (rnd_i < MINP) begin res_i = MINP[WIDTH-1:0]; sat_i = 1'b1; end
    if (rnd_q > MAXP)      begin res_q = MAXP[WIDTH-1:0]; sat_q = 1'b1; end
    else if (rnd_q < MINP) begin res_q = MINP[WIDTH-1:0]; sat_q = 1'b1; end
  end

  // Stage 2: output register; holds data and tlast while the sink stalls.
  always_ff @(posedge clk) begin
    if (in_rst) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= '0;
      s2_sat     <= 1'b0;
    end else if (pipe_adv) begin
      out_tvalid <= s1_valid;
      out_tlast  <= s1_valid & s1_last;
      s2_sat     <= s1_valid & (sat_i | sat_q);
      if (s1_valid) out_tdata <= {res_i, res_q};
    end
  end

  // Frame and saturation counters advance only on real output transfers.
  always_ff @(posedge clk) begin
    if (in_rst) begin
      frame_count <= '0;
      sat_count   <= '0;
    end else if (out_fire) begin
      if (out_tlast)                       frame_count <= frame_count + 16'd1;
      if (s2_sat && sat_count != 16'hFFFF) sat_count   <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_mtx_iq_framer.sv
// tb/tb_mtx_iq_framer.sv - directed self-checking bench for mtx_iq_framer
module tb_mtx_iq_framer;

  logic        clk = 1'b0;
  logic        reset, srst, enable, sync_ready;
  logic [15:0] gain;
  logic        in_tvalid, in_tready, in_tlast;
  logic [15:0] in_sin, in_cos;
  logic        out_tvalid, out_tlast;
  logic        out_tready = 1'b1;
  logic [31:0] out_tdata;
  logic [15:0] frame_count, sat_count;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit rnd_ready = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [15:0] fc;
    int          cy;
  } obeat_t;
  obeat_t out_q[$];

  typedef struct {
    logic [15:0] gain, sin, cos, exp_i, exp_q, exp_sat;
  } vec_t;
  vec_t vecs[12];

  logic [31:0] ref_data[768];
  logic        ref_last[768];

  logic        stalled_prev = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;

  mtx_iq_framer dut (
    .clk(clk), .reset(reset), .srst(srst), .enable(enable), .sync_ready(sync_ready),
    .gain(gain), .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tlast(in_tlast),
    .in_sin(in_sin), .in_cos(in_cos), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .out_tdata(out_tdata), .frame_count(frame_count),
    .sat_count(sat_count), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    out_tready = rnd_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stalled_prev) begin
      chk("stall_hold_data", out_tdata, hold_data);
      chk("stall_hold_last", {31'd0, out_tlast}, {31'd0, hold_last});
    end
    if (out_tvalid && out_tready)
      out_q.push_back('{out_tdata, out_tlast, frame_count, cyc});
    stalled_prev = out_tvalid && !out_tready && !srst && !reset;
    hold_data    = out_tdata;
    hold_last    = out_tlast;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [15:0] s, input logic [15:0] c, output int acc_cy);
    int k = 0;
    in_sin = s; in_cos = c; in_tvalid = 1'b1;
    @(negedge clk);
    while (!in_tready && k < 2000) begin @(negedge clk); k++; end
    if (!in_tready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_tready got 0 expected 1");
    end
    acc_cy = cyc;
    @(posedge clk); #1;
    in_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, input int limit);
    int k = 0;
    while (out_q.size() < n && k < limit) begin @(negedge clk); k++; end
    if (out_q.size() < n) begin
      checks++; errors++;
      $display("FAIL wait_out: got %0d beats expected %0d", out_q.size(), n);
    end
  endtask

  task automatic do_srst();
    srst = 1'b1; in_tvalid = 1'b0;
    @(posedge clk); #1;
    srst = 1'b0;
  endtask

  task automatic arm();
    int d;
    enable = 1'b1;
    @(posedge clk); #1;
    sync_ready = 1'b1;
    send(16'h0bad, 16'h0bad, d);
    sync_ready = 1'b0;
  endtask

  task automatic run_ramp(output int acc0);
    int acc;
    acc0 = 0;
    for (int i = 0; i < 768; i++) begin
      sync_ready = i[2];
      send(16'(i), 16'(i) ^ 16'h8000, acc);
      if (i == 0) begin acc0 = acc; gain = 16'h8000; end
      if (i == 199) gain = 16'h4000;
    end
    sync_ready = 1'b0;
  endtask

  initial begin
    int acc, acc0, sz, nlast;

    vecs[0]  = '{16'h4000, 16'h1234, 16'h5678, 16'h5678, 16'h1234, 16'd0};
    vecs[1]  = '{16'h4000, 16'hFFFF, 16'h8000, 16'h8000, 16'hFFFF, 16'd0};
    vecs[2]  = '{16'h8000, 16'h0000, 16'h7000, 16'h7FFF, 16'h0000, 16'd1};
    vecs[3]  = '{16'h8000, 16'h0000, 16'h9000, 16'h8000, 16'h0000, 16'd1};
    vecs[4]  = '{16'h2000, 16'h0003, 16'h0000, 16'h0000, 16'h0002, 16'd0};
    vecs[5]  = '{16'h2000, 16'hFFFD, 16'h0000, 16'h0000, 16'hFFFF, 16'd0};
    vecs[6]  = '{16'h2000, 16'h0001, 16'hFFFF, 16'h0000, 16'h0001, 16'd0};
    vecs[7]  = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 16'd1};
    vecs[8]  = '{16'h0000, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'd0};
    vecs[9]  = '{16'h6000, 16'h2000, 16'h5555, 16'h7FFF, 16'h3000, 16'd1};
    vecs[10] = '{16'h4001, 16'hFFFE, 16'h0002, 16'h0002, 16'hFFFE, 16'd0};
    vecs[11] = '{16'h4000, 16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF, 16'd0};

    reset = 1'b1; srst = 1'b0; enable = 1'b0; sync_ready = 1'b0; gain = 16'h4000;
    in_tvalid = 1'b0; in_tlast = 1'b0; in_sin = '0; in_cos = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_tready", {31'd0, in_tready}, 32'd0);
    chk("rst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("rst_out_tdata", out_tdata, 32'd0);
    chk("rst_out_tlast", {31'd0, out_tlast}, 32'd0);
    chk("idle_in_tready", {31'd0, in_tready}, 32'd1);

    // IDLE discards input
    out_q.delete();
    for (int i = 0; i < 5; i++) send(16'(i + 1), 16'(i + 7), acc);
    repeat (4) @(negedge clk);
    chk("idle_no_output", out_q.size(), 32'd0);
    chk("idle_state", {30'd0, state}, 32'd0);

    // Arithmetic vectors, one single-beat frame each
    for (int v = 0; v < 12; v++) begin
      do_srst();
      gain = vecs[v].gain;
      out_q.delete();
      arm();
      send(vecs[v].sin, vecs[v].cos, acc);
      wait_out(1, 20);
      @(negedge clk);
      if (out_q.size() > 0) begin
        chk($sformatf("vec%0d_data", v), out_q[0].data, {vecs[v].exp_i, vecs[v].exp_q});
        chk($sformatf("vec%0d_last", v), {31'd0, out_q[0].last}, 32'd0);
        chk($sformatf("vec%0d_latency", v), out_q[0].cy - acc, 32'd2);
      end
      chk($sformatf("vec%0d_sat_count", v), {16'd0, sat_count}, {16'd0, vecs[v].exp_sat});
    end

    // Unstalled ramp, three frames, gain changed mid-frame and sync_ready toggling
    do_srst();
    gain = 16'h4000;
    out_q.delete();
    arm();
    chk("ramp_state_run", {30'd0, state}, 32'd2);
    run_ramp(acc0);
    wait_out(768, 100);
    @(negedge clk);
    if (out_q.size() >= 768) begin
      chk("ramp_latency", out_q[0].cy - acc0, 32'd2);
      for (int j = 0; j < 768; j++) begin
        chk($sformatf("ramp_data_%0d", j), out_q[j].data, {16'(j) ^ 16'h8000, 16'(j)});
        chk($sformatf("ramp_last_%0d", j), {31'd0, out_q[j].last}, {31'd0, (j % 256) == 255});
        if (j % 256 == 0 && j > 0)
          chk($sformatf("ramp_fc_%0d", j), {16'd0, out_q[j].fc}, j / 256);
        ref_data[j] = out_q[j].data;
        ref_last[j] = out_q[j].last;
      end
    end
    chk("ramp_frame_count", {16'd0, frame_count}, 32'd3);
    chk("ramp_sat_count", {16'd0, sat_count}, 32'd0);
    chk("ramp_state_run_after", {30'd0, state}, 32'd2);

    // Same ramp with 30% output ready
    do_srst();
    gain = 16'h4000;
    out_q.delete();
    rnd_ready = 1'b1;
    arm();
    run_ramp(acc0);
    wait_out(768, 8000);
    rnd_ready = 1'b0;
    repeat (3) @(negedge clk);
    if (out_q.size() >= 768) begin
      for (int j = 0; j < 768; j++) begin
        chk($sformatf("stall_data_%0d", j), out_q[j].data, ref_data[j]);
        chk($sformatf("stall_last_%0d", j), {31'd0, out_q[j].last}, {31'd0, ref_last[j]});
      end
    end
    chk("stall_count", out_q.size(), 32'd768);
    chk("stall_frame_count", {16'd0, frame_count}, 32'd3);

    // Enable dropped at frame sample 100
    do_srst();
    gain = 16'h4000;
    out_q.delete();
    arm();
    for (int i = 0; i < 256; i++) begin
      send(16'(i), ~16'(i), acc);
      if (i == 99) enable = 1'b0;
    end
    in_sin = 16'h5a5a; in_cos = 16'ha5a5; in_tvalid = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    chk("drop_beats", out_q.size(), 32'd256);
    nlast = 0;
    foreach (out_q[j]) if (out_q[j].last) nlast++;
    chk("drop_nlast", nlast, 32'd1);
    if (out_q.size() == 256) begin
      chk("drop_final_last", {31'd0, out_q[255].last}, 32'd1);
      chk("drop_final_data", out_q[255].data, {~16'd255, 16'd255});
    end
    chk("drop_state_idle", {30'd0, state}, 32'd0);
    chk("drop_in_tready", {31'd0, in_tready}, 32'd1);
    chk("drop_frame_count", {16'd0, frame_count}, 32'd1);
    in_tvalid = 1'b0;

    // Saturating beats, then srst at frame sample 50
    do_srst();
    gain = 16'h8000;
    out_q.delete();
    arm();
    for (int i = 0; i < 40; i++) send(16'h0000, i[0] ? 16'h9000 : 16'h7000, acc);
    wait_out(40, 20);
    @(negedge clk);
    chk("sat_count_40", {16'd0, sat_count}, 32'd40);
    if (out_q.size() >= 40) begin
      for (int j = 0; j < 40; j++)
        chk($sformatf("sat_data_%0d", j), out_q[j].data, j[0] ? 32'h8000_0000 : 32'h7FFF_0000);
    end
    for (int i = 0; i < 10; i++) send(16'h0000, 16'h7000, acc);
    srst = 1'b1;
    @(negedge clk);
    chk("srst_in_tready", {31'd0, in_tready}, 32'd0);
    @(posedge clk); #1; srst = 1'b0;
    @(negedge clk);
    chk("srst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("srst_frame_count", {16'd0, frame_count}, 32'd0);
    chk("srst_sat_count", {16'd0, sat_count}, 32'd0);
    chk("srst_state_idle", {30'd0, state}, 32'd0);
    nlast = 0;
    foreach (out_q[j]) if (out_q[j].last) nlast++;
    chk("srst_no_tlast", nlast, 32'd0);
    chk("srst_no_extra", {31'd0, out_q.size() <= 50}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("srst_rearm_armed", {30'd0, state}, 32'd1);
    sz = out_q.size();
    for (int i = 0; i < 5; i++) send(16'h1111, 16'h2222, acc);
    repeat (3) @(negedge clk);
    chk("srst_wait_sync_state", {30'd0, state}, 32'd1);
    chk("srst_wait_sync_no_out", out_q.size(), sz);
    sync_ready = 1'b1;
    send(16'h3333, 16'h4444, acc);
    sync_ready = 1'b0;
    @(negedge clk);
    chk("srst_sync_run", {30'd0, state}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
